cont_tap_multi: RTL and testbench

Multi-channel, parametrised toggle-request generator and the next generation of the single-channel continue-tap cell. Each channel emits two-phase (toggle) requests: one `req` transition per tap, in bursts of 1..2^BURST_W taps per `fire`. A channel either paces each tap on a two-phase `ack` (MODE=1) or free-runs one tap per `trig` edge (MODE=0). It sits at the sender side of the handshake fabric, clocked by the local trigger, and adds per-channel tap counting and error flags.

---
 rtl/cont_tap_multi.sv | 135 +++++++++++++
 tb/tb_cont_tap_multi.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cont_tap_multi.sv
// cont_tap_multi
//   Multi-channel two-phase (toggle) request generator. Each channel issues
//   bursts of 1..2^BURST_W taps per accepted fire; a tap toggles req[i] and
//   bumps tap_cnt[i]. With MODE=1 every tap after the first waits for the
//   matching ack; with MODE=0 taps free-run one per trig edge and ack is
//   ignored. Protocol errors raise a sticky per-channel err flag.
//
// Ports
//   trig       in   clock, all state moves on the rising edge
//   rst        in   asynchronous active-high reset
//   fire       in   [CH]          per-channel burst start
//   burst_len  in   [CH*BURST_W]  taps per burst minus one, channel i at [i*BURST_W +: BURST_W]
//   ack        in   [CH]          two-phase acknowledge (MODE=1 only)
//   req        out  [CH]          two-phase request, one toggle per tap
//   busy       out  [CH]          channel is inside a burst
//   tap_cnt    out  [CH*CNT_W]    running tap count per channel, wraps
//   err        out  [CH]          sticky protocol error flag
//   dbg_state  out  [2*CH]        per-channel FSM state, channel i at [2*i +: 2]
//
// Handshake: a tap is outstanding while req[i] != ack[i]; the receiver
// completes it by copying req[i] onto ack[i]. The next tap goes out on the
// edge that samples ack[i] == req[i]. In IDLE nothing is outstanding, so an
// ack that differs from req there is a spurious acknowledge.
module cont_tap_multi #(
  parameter int unsigned CH      = 4,
  parameter int unsigned BURST_W = 4,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned MODE    = 1
) (
  input  logic                  trig,
  input  logic                  rst,
  input  logic [CH-1:0]         fire,
  input  logic [CH*BURST_W-1:0] burst_len,
  input  logic [CH-1:0]         ack,
  output logic [CH-1:0]         req,
  output logic [CH-1:0]         busy,
  output logic [CH*CNT_W-1:0]   tap_cnt,
  output logic [CH-1:0]         err,
  output logic [2*CH-1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    ISSUE = 2'd2
  } state_t;

  state_t             state_q  [CH];
  state_t             state_d  [CH];
  logic [BURST_W-1:0] remain_q [CH];
  logic [BURST_W-1:0] remain_d [CH];
  logic [CNT_W-1:0]   cnt_q    [CH];
  logic [CNT_W-1:0]   cnt_d    [CH];
  logic [CH-1:0]      req_q, req_d;
  logic [CH-1:0]      err_q, err_d;
  logic [CH-1:0]      tap;

  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    err_d    = err_q;
    tap      = '0;
    for (int i = 0; i < CH; i++) begin
      case (state_q[i])
        IDLE: begin
          if (fire[i]) begin
            remain_d[i] = burst_len[i*BURST_W +: BURST_W];
            tap[i]      = 1'b1;
            if (MODE != 0) begin
              state_d[i] = WAIT;
            end else if (burst_len[i*BURST_W +: BURST_W] != '0) begin
              state_d[i] = ISSUE;
            end
          end
          if ((MODE != 0) && (ack[i] != req_q[i])) begin
            err_d[i] = 1'b1;
          end
        end
        WAIT: begin
          if (ack[i] == req_q[i]) begin
            if (remain_q[i] == '0) begin
              state_d[i] = IDLE;
            end else begin
              remain_d[i] = remain_q[i] - BURST_W'(1);
              tap[i]      = 1'b1;
            end
          end
          // fire is only accepted in IDLE, including on the returning edge
          if (fire[i]) err_d[i] = 1'b1;
        end
        ISSUE: begin
          tap[i]      = 1'b1;
          remain_d[i] = remain_q[i] - BURST_W'(1);
          if (remain_q[i] == BURST_W'(1)) state_d[i] = IDLE;
          if (fire[i]) err_d[i] = 1'b1;
        end
        default: begin
          state_d[i] = IDLE;
        end
      endcase
      cnt_d[i] = cnt_q[i] + CNT_W'(tap[i]);
    end
    req_d = req_q ^ tap;
  end

  always_ff @(posedge trig or posedge rst) begin
    if (rst) begin
      req_q <= '0;
      err_q <= '0;
      for (int i = 0; i < CH; i++) begin
        state_q[i]  <= IDLE;
        remain_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
    end else begin
      req_q <= req_d;
      err_q <= err_d;
      for (int i = 0; i < CH; i++) begin
        state_q[i]  <= state_d[i];
        remain_q[i] <= remain_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
    end
  end

  assign req = req_q;
  assign err = err_q;

  for (genvar g = 0; g < CH; g++) begin : g_out
    assign busy[g]                   = (state_q[g] != IDLE);
    assign tap_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
    assign dbg_state[2*g +: 2]       = state_q[g];
  end

endmodule

// File: tb/tb_cont_tap_multi.sv
module tb_cont_tap_multi;
  localparam int CH = 4;
  localparam int BW = 4;
  localparam int CW = 8;

  // clock / reset
  logic trig = 1'b0;
  logic rst  = 1'b1;
  always #5 trig = ~trig;

  logic [CH-1:0]    fire1 = '0, fire0 = '0, ack1 = '0, ack0 = '0;
  logic [CH*BW-1:0] burst_len = '0;
  logic [CH-1:0]    req1, busy1, err1, req0, busy0, err0;
  logic [CH*CW-1:0] cnt1, cnt0;
  logic [2*CH-1:0]  dbg1, dbg0;

  cont_tap_multi #(.CH(CH), .BURST_W(BW), .CNT_W(CW), .MODE(1)) dut1 (
    .trig(trig), .rst(rst), .fire(fire1), .burst_len(burst_len), .ack(ack1),
    .req(req1), .busy(busy1), .tap_cnt(cnt1), .err(err1), .dbg_state(dbg1));

  cont_tap_multi #(.CH(CH), .BURST_W(BW), .CNT_W(CW), .MODE(0)) dut0 (
    .trig(trig), .rst(rst), .fire(fire0), .burst_len(burst_len), .ack(ack0),
    .req(req0), .busy(busy0), .tap_cnt(cnt0), .err(err0), .dbg_state(dbg0));

  // scoreboard: reference totals kept as plain integers
  int checks = 0;
  int failures = 0;
  int exp_cnt1 [CH];
  int exp_cnt0 [CH];
  logic [CH-1:0] exp_err1, exp_err0;
  logic [CW-1:0] exp_q[$];

  function automatic logic [CW-1:0] slice_cnt(input logic [CH*CW-1:0] v, input int ch);
    return v[ch*CW +: CW];
  endfunction

  function automatic logic [CW-1:0] mod_cnt(input int v);
    return CW'(v % (1 << CW));
  endfunction

  task automatic tick();
    @(posedge trig);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; fire1 = '0; fire0 = '0; ack1 = '0; ack0 = '0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < CH; i++) begin exp_cnt1[i] = 0; exp_cnt0[i] = 0; end
    exp_err1 = '0; exp_err0 = '0;
  endtask

  task automatic test_reset();
    checks++;
    if ({req1, busy1, err1, cnt1} !== '0) begin
      failures++; $display("FAIL reset_mode1 got=%0h exp=0", {req1, busy1, err1, cnt1});
    end
    checks++;
    if ({req0, busy0, err0, cnt0} !== '0) begin
      failures++; $display("FAIL reset_mode0 got=%0h exp=0", {req0, busy0, err0, cnt0});
    end
    repeat (3) tick();
    checks++;
    if ({req1, busy1, req0, busy0, cnt1, cnt0} !== '0) begin
      failures++; $display("FAIL idle_quiet got=%0h exp=0", {req1, busy1, req0, busy0, cnt1, cnt0});
    end
  endtask

  task automatic test_single_tap();
    burst_len = '0;
    fire1[0] = 1'b1;
    tick();
    fire1[0] = 1'b0;
    exp_cnt1[0] += 1;
    checks++;
    if ({req1[0], busy1[0]} !== 2'b11) begin
      failures++; $display("FAIL single_first req/busy got=%b exp=11", {req1[0], busy1[0]});
    end
    checks++;
    if (slice_cnt(cnt1, 0) !== mod_cnt(exp_cnt1[0])) begin
      failures++; $display("FAIL single_cnt got=%0d exp=%0d", slice_cnt(cnt1, 0), mod_cnt(exp_cnt1[0]));
    end
    tick();
    checks++;
    if ({req1[0], busy1[0]} !== 2'b11) begin
      failures++; $display("FAIL single_hold req/busy got=%b exp=11", {req1[0], busy1[0]});
    end
    ack1[0] = 1'b1;
    tick();
    checks++;
    if ({req1[0], busy1[0], err1} !== {1'b1, 1'b0, exp_err1}) begin
      failures++; $display("FAIL single_done req/busy/err got=%b exp=%b", {req1[0], busy1[0], err1}, {1'b1, 1'b0, exp_err1});
    end
  endtask

  // dly < 0 picks a random ack delay per tap
  task automatic test_burst_ack(input int ch, input int bl, input int dly);
    logic r0, prev;
    int toggles, d;
    r0 = req1[ch];
    burst_len[ch*BW +: BW] = BW'(bl);
    fire1[ch] = 1'b1;
    tick();
    fire1[ch] = 1'b0;
    burst_len = BW*CH'($urandom);
    toggles = (req1[ch] !== r0) ? 1 : 0;
    for (int t = 1; t <= bl + 1; t++) begin
      d = (dly < 0) ? int'($urandom_range(0, 3)) : dly;
      prev = req1[ch];
      repeat (d) begin
        tick();
        checks++;
        if ({req1[ch], busy1[ch]} !== {prev, 1'b1}) begin
          failures++; $display("FAIL burst_hold ch=%0d req/busy got=%b exp=%b", ch, {req1[ch], busy1[ch]}, {prev, 1'b1});
        end
      end
      ack1[ch] = req1[ch];
      tick();
      if (req1[ch] !== prev) toggles++;
      checks++;
      if (t <= bl) begin
        if ({req1[ch], busy1[ch]} !== {~prev, 1'b1}) begin
          failures++; $display("FAIL burst_step ch=%0d tap=%0d req/busy got=%b exp=%b", ch, t + 1, {req1[ch], busy1[ch]}, {~prev, 1'b1});
        end
      end else begin
        if ({req1[ch], busy1[ch]} !== {prev, 1'b0}) begin
          failures++; $display("FAIL burst_end ch=%0d req/busy got=%b exp=%b", ch, {req1[ch], busy1[ch]}, {prev, 1'b0});
        end
      end
    end
    exp_cnt1[ch] += bl + 1;
    checks++;
    if (toggles !== bl + 1) begin
      failures++; $display("FAIL burst_toggles ch=%0d got=%0d exp=%0d", ch, toggles, bl + 1);
    end
    checks++;
    if (req1[ch] !== (r0 ^ 1'((bl + 1) % 2))) begin
      failures++; $display("FAIL burst_parity ch=%0d got=%b exp=%b", ch, req1[ch], r0 ^ 1'((bl + 1) % 2));
    end
    checks++;
    if ({slice_cnt(cnt1, ch), err1} !== {mod_cnt(exp_cnt1[ch]), exp_err1}) begin
      failures++; $display("FAIL burst_cnt_err ch=%0d got=%0h exp=%0h", ch, {slice_cnt(cnt1, ch), err1}, {mod_cnt(exp_cnt1[ch]), exp_err1});
    end
  endtask

  task automatic test_free_run(input int ch, input int bl);
    logic prev;
    prev = req0[ch];
    burst_len[ch*BW +: BW] = BW'(bl);
    fire0[ch] = 1'b1;
    for (int j = 1; j <= bl + 1; j++) begin
      ack0 = CH'($urandom);
      tick();
      fire0[ch] = 1'b0;
      burst_len = BW*CH'($urandom);
      checks++;
      if ({req0[ch], busy0[ch]} !== {~prev, 1'(j <= bl)}) begin
        failures++; $display("FAIL free_step ch=%0d edge=%0d req/busy got=%b exp=%b", ch, j, {req0[ch], busy0[ch]}, {~prev, 1'(j <= bl)});
      end
      prev = req0[ch];
    end
    tick();
    exp_cnt0[ch] += bl + 1;
    checks++;
    if ({req0[ch], busy0[ch]} !== {prev, 1'b0}) begin
      failures++; $display("FAIL free_after ch=%0d req/busy got=%b exp=%b", ch, {req0[ch], busy0[ch]}, {prev, 1'b0});
    end
    checks++;
    if ({slice_cnt(cnt0, ch), err0} !== {mod_cnt(exp_cnt0[ch]), exp_err0}) begin
      failures++; $display("FAIL free_cnt_err ch=%0d got=%0h exp=%0h", ch, {slice_cnt(cnt0, ch), err0}, {mod_cnt(exp_cnt0[ch]), exp_err0});
    end
  endtask

  task automatic test_errors();
    do_reset();
    // fire while waiting on ack: dropped
    burst_len = '0;
    burst_len[0 +: BW] = BW'(2);
    fire1[0] = 1'b1;
    tick();
    tick();
    fire1[0] = 1'b0;
    exp_cnt1[0] = 1; exp_err1[0] = 1'b1;
    checks++;
    if ({err1, slice_cnt(cnt1, 0), busy1[0]} !== {exp_err1, mod_cnt(exp_cnt1[0]), 1'b1}) begin
      failures++; $display("FAIL err_fire_wait got=%0h exp=%0h", {err1, slice_cnt(cnt1, 0), busy1[0]}, {exp_err1, mod_cnt(exp_cnt1[0]), 1'b1});
    end
    for (int c = 0; c < 20 && busy1[0]; c++) begin
      ack1[0] = req1[0];
      tick();
    end
    exp_cnt1[0] = 3;
    checks++;
    if ({err1, slice_cnt(cnt1, 0), busy1[0]} !== {exp_err1, mod_cnt(exp_cnt1[0]), 1'b0}) begin
      failures++; $display("FAIL err_sticky got=%0h exp=%0h", {err1, slice_cnt(cnt1, 0), busy1[0]}, {exp_err1, mod_cnt(exp_cnt1[0]), 1'b0});
    end
    // spurious ack on idle channel 1
    ack1[1] = 1'b1;
    tick();
    ack1[1] = 1'b0;
    exp_err1[1] = 1'b1;
    tick();
    checks++;
    if ({err1, req1[1], busy1[1], slice_cnt(cnt1, 1)} !== {exp_err1, 1'b0, 1'b0, CW'(0)}) begin
      failures++; $display("FAIL err_spurious got=%0h exp=%0h", {err1, req1[1], busy1[1], slice_cnt(cnt1, 1)}, {exp_err1, 1'b0, 1'b0, CW'(0)});
    end
    // free-run: fire held into the edge where the burst returns to IDLE
    burst_len[3*BW +: BW] = BW'(1);
    fire0[3] = 1'b1;
    tick();
    tick();
    fire0[3] = 1'b0;
    tick();
    exp_cnt0[3] = 2; exp_err0[3] = 1'b1;
    checks++;
    if ({err0, slice_cnt(cnt0, 3), busy0[3], req0[3]} !== {exp_err0, mod_cnt(exp_cnt0[3]), 1'b0, 1'b0}) begin
      failures++; $display("FAIL err_return_edge got=%0h exp=%0h", {err0, slice_cnt(cnt0, 3), busy0[3], req0[3]}, {exp_err0, mod_cnt(exp_cnt0[3]), 1'b0, 1'b0});
    end
  endtask

  task automatic test_wrap();
    do_reset();
    burst_len = '0;
    fire0[2] = 1'b1;
    repeat (255) tick();
    checks++;
    if ({slice_cnt(cnt0, 2), busy0[2]} !== {CW'(255), 1'b0}) begin
      failures++; $display("FAIL wrap_255 got=%0h exp=%0h", {slice_cnt(cnt0, 2), busy0[2]}, {CW'(255), 1'b0});
    end
    tick();
    fire0[2] = 1'b0;
    exp_cnt0[2] = 256;
    checks++;
    if ({slice_cnt(cnt0, 2), req0[2], err0} !== {mod_cnt(exp_cnt0[2]), 1'b0, exp_err0}) begin
      failures++; $display("FAIL wrap_zero got=%0h exp=%0h", {slice_cnt(cnt0, 2), req0[2], err0}, {mod_cnt(exp_cnt0[2]), 1'b0, exp_err0});
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    burst_len = {CH{BW'(5)}};
    fire1[1] = 1'b1; fire0[0] = 1'b1;
    tick();
    fire1 = '0; fire0 = '0;
    checks++;
    if ({req1[1], busy1[1], req0[0], busy0[0]} !== 4'b1111) begin
      failures++; $display("FAIL mid_busy got=%b exp=1111", {req1[1], busy1[1], req0[0], busy0[0]});
    end
    #2;
    rst = 1'b1; ack1 = '0;
    #1;
    checks++;
    if ({req1, busy1, cnt1, err1, req0, busy0, cnt0, err0} !== '0) begin
      failures++; $display("FAIL mid_reset got=%0h exp=0", {req1, busy1, cnt1, err1, req0, busy0, cnt0, err0});
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < CH; i++) begin exp_cnt1[i] = 0; exp_cnt0[i] = 0; end
    exp_err1 = '0; exp_err0 = '0;
  endtask

  task automatic test_back_to_back();
    int tg1 [CH];
    int tg0 [CH];
    int bl  [CH];
    logic [CH-1:0] p1, p0;
    do_reset();
    for (int i = 0; i < CH; i++) begin
      bl[i] = i * 4 + int'($urandom_range(0, 3));
      burst_len[i*BW +: BW] = BW'(bl[i]);
    end
    fire1 = '1; fire0 = '1;
    tick();
    fire1 = '0; fire0 = '0;
    for (int i = 0; i < CH; i++) begin tg1[i] = int'(req1[i]); tg0[i] = int'(req0[i]); end
    for (int c = 0; c < 40 && (busy1 != '0 || busy0 != '0); c++) begin
      ack1 = req1;
      ack0 = CH'($urandom);
      p1 = req1; p0 = req0;
      tick();
      for (int i = 0; i < CH; i++) begin
        tg1[i] += int'(req1[i] ^ p1[i]);
        tg0[i] += int'(req0[i] ^ p0[i]);
      end
    end
    checks++;
    if ({busy1, busy0} !== '0) begin
      failures++; $display("FAIL b2b_timeout busy got=%b exp=0", {busy1, busy0});
    end
    for (int i = 0; i < CH; i++) begin
      exp_q.push_back(CW'(bl[i] + 1));
      exp_q.push_back(CW'(bl[i] + 1));
      exp_cnt1[i] += bl[i] + 1;
      exp_cnt0[i] += bl[i] + 1;
    end
    for (int i = 0; i < CH; i++) begin
      logic [CW-1:0] e;
      e = exp_q.pop_front();
      checks++;
      if (CW'(tg1[i]) !== e || slice_cnt(cnt1, i) !== mod_cnt(exp_cnt1[i])) begin
        failures++; $display("FAIL b2b_mode1 ch=%0d toggles=%0d cnt=%0d exp=%0d", i, tg1[i], slice_cnt(cnt1, i), e);
      end
      e = exp_q.pop_front();
      checks++;
      if (CW'(tg0[i]) !== e || slice_cnt(cnt0, i) !== mod_cnt(exp_cnt0[i])) begin
        failures++; $display("FAIL b2b_mode0 ch=%0d toggles=%0d cnt=%0d exp=%0d", i, tg0[i], slice_cnt(cnt0, i), e);
      end
    end
    checks++;
    if ({err1, err0} !== {exp_err1, exp_err0}) begin
      failures++; $display("FAIL b2b_err got=%b exp=%b", {err1, err0}, {exp_err1, exp_err0});
    end
  endtask

  initial begin
    #1;
    do_reset();
    test_reset();
    test_single_tap();
    test_burst_ack(0, 3, 2);
    for (int k = 0; k < 8; k++) begin
      test_burst_ack(int'($urandom_range(0, CH - 1)), int'($urandom_range(0, 15)), -1);
    end
    test_free_run(2, 5);
    test_free_run(1, 0);
    for (int k = 0; k < 8; k++) begin
      test_free_run(int'($urandom_range(0, CH - 1)), int'($urandom_range(0, 15)));
    end
    test_errors();
    test_wrap();
    test_reset_mid();
    repeat (3) test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
